// File: rtl/conv_engine.sv
// Sequential 3x3-over-4x4 valid-region correlation engine with a registered valid/ready result port.
// Optional build macro CONV_SAT_EN clamps out_data to 2^DATA_W-1; the accumulator stays full width.
module conv_engine #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] i00,
   input  logic [DATA_W-1:0] i01,
   input  logic [DATA_W-1:0] i02,
   input  logic [DATA_W-1:0] i03,
   input  logic [DATA_W-1:0] i10,
   input  logic [DATA_W-1:0] i11,
   input  logic [DATA_W-1:0] i12,
   input  logic [DATA_W-1:0] i13,
   input  logic [DATA_W-1:0] i20,
   input  logic [DATA_W-1:0] i21,
   input  logic [DATA_W-1:0] i22,
   input  logic [DATA_W-1:0] i23,
   input  logic [DATA_W-1:0] i30,
   input  logic [DATA_W-1:0] i31,
   input  logic [DATA_W-1:0] i32,
   input  logic [DATA_W-1:0] i33,
   input  logic [DATA_W-1:0] f00,
   input  logic [DATA_W-1:0] f01,
   input  logic [DATA_W-1:0] f02,
   input  logic [DATA_W-1:0] f10,
   input  logic [DATA_W-1:0] f11,
   input  logic [DATA_W-1:0] f12,
   input  logic [DATA_W-1:0] f20,
   input  logic [DATA_W-1:0] f21,
   input  logic [DATA_W-1:0] f22,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_row,
   output logic              out_col,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [1:0]        m_q, m_d;
   logic [1:0]        n_q, n_d;
   logic [1:0]        pix_q, pix_d;
   logic              out_valid_d;
   logic [ACC_W-1:0]  out_data_d;
   logic              out_row_d;
   logic              out_col_d;
   logic              busy_d;
   logic              done_d;
   logic              snap_c;

   logic [DATA_W-1:0] img_in [16];
   logic [DATA_W-1:0] flt_in [9];
   logic [DATA_W-1:0] img_q  [16];
   logic [DATA_W-1:0] flt_q  [9];

   logic [1:0]        row_c;
   logic [1:0]        col_c;
   logic [3:0]        img_idx_c;
   logic [3:0]        flt_idx_c;
   logic [PROD_W-1:0] prod_c;
   logic [ACC_W-1:0]  acc_sum_c;
   logic [ACC_W-1:0]  result_c;

   // Flattened operand views, row-major.
   assign img_in = '{i00, i01, i02, i03, i10, i11, i12, i13,
                     i20, i21, i22, i23, i30, i31, i32, i33};
   assign flt_in = '{f00, f01, f02, f10, f11, f12, f20, f21, f22};

   // Current tap: image(r+m, c+n) * filter(m, n), with (r, c) taken from the pixel index.
   assign row_c     = {1'b0, pix_q[1]} + m_q;
   assign col_c     = {1'b0, pix_q[0]} + n_q;
   assign img_idx_c = {row_c, col_c};
   assign flt_idx_c = 4'(m_q) * 4'd3 + 4'(n_q);
   assign prod_c    = img_q[img_idx_c] * flt_q[flt_idx_c];
   assign acc_sum_c = acc_q + ACC_W'(prod_c);

`ifdef CONV_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});
   assign result_c = (acc_sum_c > SAT_MAX) ? SAT_MAX : acc_sum_c;
`else
   assign result_c = acc_sum_c;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      m_d         = m_q;
      n_d         = n_q;
      pix_d       = pix_q;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      out_row_d   = out_row;
      out_col_d   = out_col;
      busy_d      = busy;
      done_d      = 1'b0;
      snap_c      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               snap_c  = 1'b1;
               state_d = MAC;
               acc_d   = '0;
               m_d     = 2'd0;
               n_d     = 2'd0;
               pix_d   = 2'd0;
               busy_d  = 1'b1;
            end
         end
         MAC: begin
            acc_d = acc_sum_c;
            if (n_q == 2'd2) begin
               n_d = 2'd0;
               if (m_q == 2'd2) begin
                  m_d         = 2'd0;
                  state_d     = OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = result_c;
                  out_row_d   = pix_q[1];
                  out_col_d   = pix_q[0];
               end else begin
                  m_d = m_q + 2'd1;
               end
            end else begin
               n_d = n_q + 2'd1;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               if (pix_q == 2'd3) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pix_d   = pix_q + 2'd1;
                  state_d = MAC;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         m_q       <= 2'd0;
         n_q       <= 2'd0;
         pix_q     <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= 1'b0;
         out_col   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         m_q       <= m_d;
         n_q       <= n_d;
         pix_q     <= pix_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         out_row   <= out_row_d;
         out_col   <= out_col_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Operand snapshot, taken only when a computation is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) img_q[i] <= '0;
         for (int i = 0; i < 9; i++)  flt_q[i] <= '0;
      end else if (snap_c) begin
         for (int i = 0; i < 16; i++) img_q[i] <= img_in[i];
         for (int i = 0; i < 9; i++)  flt_q[i] <= flt_in[i];
      end
   end

endmodule

// File: doc/conv_engine.md
# conv_engine

Sequential 2-D correlation engine that reads the 4x4 image and 3x3 filter the memory block presents on parallel 8-bit buses and produces the 2x2 valid-region output. It is the consumer side of the memory block's output interface. On `start` it snapshots all 25 operands, then computes each output pixel with one multiply-accumulate per cycle. Each result is delivered over a valid/ready handshake to the downstream result sink.

## Interface
- `DATA_W`, default 8: operand width; image and filter values are unsigned.
- `ACC_W`, default 20: accumulator and result width; must be at least 2*DATA_W+4, and 9*255*255 = 585225 fits in 20 bits.

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request one full 2x2 computation; sampled only in IDLE.
- `i00`…`i33` input, DATA_W bits each: 16 image ports `iRC`, R = row 0..3, C = col 0..3.
- `f00`…`f22` input, DATA_W bits each: 9 filter ports `fRC`, R and C = 0..2.
- `out_valid` output, 1 bit: `out_data` holds a finished pixel.
- `out_ready` input, 1 bit: downstream accepts the pixel.
- `out_data` output, ACC_W bits: pixel value.
- `out_row` output, 1 bit: output pixel row.
- `out_col` output, 1 bit: output pixel column.
- `busy` output, 1 bit: computation in progress.
- `done` output, 1 bit: one-cycle pulse after the last pixel transfers.

## Operation
- Function: out[r][c] = Σ(m,n = 0..2) i[r+m][c+n] * f[m][n]. No kernel flip, unsigned, full precision in ACC_W.
- FSM states:
  - IDLE: `busy`=0. With `start`=1, the clock edge snapshots all 25 inputs into internal registers, clears the accumulator, sets the pixel index to 0, and moves to MAC.
  - MAC: kernel index k runs 0..8 in row-major (m,n) order, one product added per cycle. After k=8 is accumulated, the FSM moves to OUT.
  - OUT: `out_valid`=1. `out_data`, `out_row` and `out_col` are held stable until `out_valid`&&`out_ready`. On transfer:
    - pixel index < 3: increment the index, clear the accumulator, return to MAC.
    - pixel index = 3: return to IDLE and pulse `done`.
- Pixel order is (0,0), (0,1), (1,0), (1,1).
- Inputs are not observed after the snapshot; input changes mid-computation have no effect.
- `start` during MAC or OUT is ignored, not queued. `start` in the `done` cycle is accepted, because the FSM is already in IDLE.
- `out_ready` outside OUT is ignored.
- `rst` values, all outputs: `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `busy`=0, `done`=0. FSM goes to IDLE; the accumulator, indices and snapshot clear.
- Reset mid-operation discards partial results; no pixel is emitted.

## Timing
- `start` sampled at edge T:
  - `busy`=1 from edge T.
  - MAC runs on edges T+1..T+9.
  - `out_valid` rises after edge T+9.
- With `out_ready` held 1:
  - a transfer occurs every 10 cycles, at edges T+10, T+20, T+30 and T+40.
  - `busy` falls and `done`=1 for one cycle after edge T+40.
- Each cycle `out_ready`=0 in OUT adds one cycle of stall. Throughput limit: 10 cycles per pixel.
- All outputs are registered; there is no combinational path from `out_ready` to any output.

## Configuration
- `CONV_SAT_EN`
  - Defined: `out_data` is clamped to 2^DATA_W−1 (255 at the default width), with the upper ACC_W−DATA_W bits 0. The accumulator itself stays full width.
  - Undefined: `out_data` is the full ACC_W result, unclamped.

## Test plan
- Image rows {9,8,2,6}, {0,4,1,6}, {4,10,1,1}, {2,2,9,9}; filter rows {3,2,0}, {2,0,1}, {3,1,1}; `out_ready`=1; pulse `start` -> pixels 67, 74, 34, 59 at (row,col) (0,0), (0,1), (1,0), (1,1) on edges T+10/20/30/40; `done` pulses once after T+40.
- Same data, `out_ready`=0 for 5 cycles after the first `out_valid` -> `out_valid` stays 1 and `out_data`=67 is held stable; the first transfer occurs 5 cycles late and later pixels shift by 5.
- All 25 inputs = 255:
  - `CONV_SAT_EN` undefined -> every pixel = 585225.
  - `CONV_SAT_EN` defined -> every pixel = 255.
- `start` re-asserted at T+5 and T+15 -> ignored; exactly 4 pixels and 1 `done`. Inputs changed to 0 at T+1 -> results remain 67, 74, 34, 59.
- `rst` asserted at T+14 -> all outputs 0 on the next cycle; no further `out_valid`. A fresh `start` then yields 67, 74, 34, 59 with nominal timing.
- `start` held 1 through the `done` cycle -> a second run begins immediately with identical results and timing.
